// File: rtl/axis_position_integrator_if.sv
// Bundle of the step/write/status signals for axis_position_integrator.
// The master side issues steps and register writes. The slave side is the integrator.
interface axis_position_integrator_if #(
  parameter int WIDTH = 16,
  parameter int AXES  = 3
);
  localparam int AW = (AXES > 1) ? $clog2(AXES) : 1;

  logic                    step;
  logic                    wr_en;
  logic                    wr_pos;
  logic [AW-1:0]           wr_axis;
  logic [WIDTH-1:0]        wr_data;
  logic                    clr_ovf;
  logic [AXES*WIDTH-1:0]   pos;
  logic [AXES-1:0]         ovf;
  logic                    busy;
  logic                    done;

  modport master (
    output step, wr_en, wr_pos, wr_axis, wr_data, clr_ovf,
    input  pos, ovf, busy, done
  );

  modport slave (
    input  step, wr_en, wr_pos, wr_axis, wr_data, clr_ovf,
    output pos, ovf, busy, done
  );
endinterface

// File: rtl/axis_position_integrator.sv
// Multi-axis position integrator.
// Each step runs one pass of pos += vel over all axes, one axis per cycle.
// A single adder is shared by all axes. Overflow either saturates or wraps.
module axis_position_integrator #(
  parameter int WIDTH = 16,
  parameter int VW    = 8,
  parameter int AXES  = 3,
  parameter int SAT   = 1
) (
  input logic clk,
  input logic rst,
  axis_position_integrator_if.slave bus
);
  localparam int AW = (AXES > 1) ? $clog2(AXES) : 1;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  localparam logic signed [WIDTH-1:0] POS_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0] POS_MIN = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [AW-1:0]           LAST_IDX = AW'(AXES - 1);

  logic signed [WIDTH-1:0] r_pos [AXES];
  logic signed [VW-1:0]    r_vel [AXES];
  logic [AXES-1:0]         r_ovf;
  logic                    r_busy;
  logic                    r_done;
  logic [AW-1:0]           r_idx;
  logic [0:0]              r_state;

  logic                    w_update;
  logic signed [WIDTH-1:0] w_curPos;
  logic signed [VW-1:0]    w_curVel;
  logic signed [WIDTH:0]   w_sum;
  logic                    w_ovf;
  logic signed [WIDTH-1:0] w_result;
  logic [AXES-1:0]         w_hit;
  logic [AXES-1:0]         w_posWr;
  logic [AXES-1:0]         w_velWr;

  assign w_update = (r_state == S_RUN);

  // Select the current axis operands and decode per-axis write/update strobes.
  always_comb begin
    w_curPos = '0;
    w_curVel = '0;
    w_hit    = '0;
    w_posWr  = '0;
    w_velWr  = '0;
    for (int i = 0; i < AXES; i++) begin
      if (r_idx == AW'(i)) begin
        w_curPos = r_pos[i];
        w_curVel = r_vel[i];
      end
      w_hit[i]   = w_update && (r_idx == AW'(i));
      w_posWr[i] = bus.wr_en && bus.wr_pos && (bus.wr_axis == AW'(i));
      w_velWr[i] = bus.wr_en && !bus.wr_pos && (bus.wr_axis == AW'(i));
    end
  end

  // Shared adder: widen by one bit, detect overflow, then saturate or wrap.
  always_comb begin
    w_sum = {w_curPos[WIDTH-1], w_curPos}
          + {{(WIDTH+1-VW){w_curVel[VW-1]}}, w_curVel};
    w_ovf = w_sum[WIDTH] ^ w_sum[WIDTH-1];
    if (w_ovf && (SAT != 0)) begin
      w_result = w_sum[WIDTH] ? POS_MIN : POS_MAX;
    end else begin
      w_result = w_sum[WIDTH-1:0];
    end
  end

  // Pass sequencer: IDLE accepts a step, RUN walks the axes and pulses done on the last one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (r_state == S_IDLE) begin
        if (bus.step) begin
          r_state <= S_RUN;
          r_idx   <= '0;
          r_busy  <= 1'b1;
        end
      end else begin
        if (r_idx == LAST_IDX) begin
          r_state <= S_IDLE;
          r_idx   <= '0;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
        end else begin
          r_idx <= r_idx + AW'(1);
        end
      end
    end
  end

  // Axis registers: a position write beats the integration update on the same axis.
  // A velocity write lands after the update has already used the old value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < AXES; i++) begin
        r_pos[i] <= '0;
        r_vel[i] <= '0;
      end
      r_ovf <= '0;
    end else begin
      if (bus.clr_ovf) begin
        r_ovf <= '0;
      end
      for (int i = 0; i < AXES; i++) begin
        if (w_hit[i] && !w_posWr[i]) begin
          r_pos[i] <= w_result;
          if (w_ovf) begin
            r_ovf[i] <= 1'b1;
          end
        end
        if (w_posWr[i]) begin
          r_pos[i] <= bus.wr_data;
        end
        if (w_velWr[i]) begin
          r_vel[i] <= bus.wr_data[VW-1:0];
        end
      end
    end
  end

  // Flatten the position registers onto the output bus.
  always_comb begin
    bus.pos = '0;
    for (int i = 0; i < AXES; i++) begin
      bus.pos[i*WIDTH +: WIDTH] = r_pos[i];
    end
  end

  assign bus.ovf  = r_ovf;
  assign bus.busy = r_busy;
  assign bus.done = r_done;
endmodule

// File: tb/tb_axis_position_integrator.sv
// Self-checking bench for axis_position_integrator.
// It drives a saturating and a wrapping instance with the same stimulus.
// Both are checked against a pass-level reference model.
module tb_axis_position_integrator;
  localparam int WIDTH = 16;
  localparam int VW    = 8;
  localparam int AXES  = 3;
  localparam int PMAX  = 32767;
  localparam int PMIN  = -32768;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic        tStep  = 1'b0;
  logic        tWrEn  = 1'b0;
  logic        tWrPos = 1'b0;
  logic [1:0]  tAxis  = '0;
  logic [15:0] tData  = '0;
  logic        tClr   = 1'b0;

  int checks   = 0;
  int errors   = 0;
  int doneSeen = 0;

  // Reference model state. Index 0 is the saturating instance and index 1 is the wrapping one.
  int mPos [2][AXES];
  int mVel [2][AXES];
  bit mOvf [2][AXES];
  bit mBusy;
  bit mDone;
  int edgeCnt   = 0;
  int passStart = -100;

  always #5 clk = ~clk;

  axis_position_integrator_if #(.WIDTH(WIDTH), .AXES(AXES)) ifS ();
  axis_position_integrator_if #(.WIDTH(WIDTH), .AXES(AXES)) ifW ();

  assign ifS.step = tStep;   assign ifW.step = tStep;
  assign ifS.wr_en = tWrEn;  assign ifW.wr_en = tWrEn;
  assign ifS.wr_pos = tWrPos; assign ifW.wr_pos = tWrPos;
  assign ifS.wr_axis = tAxis; assign ifW.wr_axis = tAxis;
  assign ifS.wr_data = tData; assign ifW.wr_data = tData;
  assign ifS.clr_ovf = tClr;  assign ifW.clr_ovf = tClr;

  axis_position_integrator #(.WIDTH(WIDTH), .VW(VW), .AXES(AXES), .SAT(1)) dutSat (
    .clk(clk), .rst(rst), .bus(ifS)
  );
  axis_position_integrator #(.WIDTH(WIDTH), .VW(VW), .AXES(AXES), .SAT(0)) dutWrap (
    .clk(clk), .rst(rst), .bus(ifW)
  );

  typedef struct {
    logic        step;
    logic        wrEn;
    logic        wrPos;
    logic [1:0]  axis;
    logic [15:0] data;
    logic        clr;
    int          expPos0;
    int          expPos1;
    int          expPos2;
    logic        expBusy;
    logic        expDone;
  } vec_t;

  vec_t vecs [8];

  function automatic int dutPos(input int m, input int a);
    logic signed [15:0] t;
    t = (m == 0) ? ifS.pos[a*WIDTH +: WIDTH] : ifW.pos[a*WIDTH +: WIDTH];
    return int'(t);
  endfunction

  function automatic int dutOvf(input int m, input int a);
    return (m == 0) ? int'(ifS.ovf[a]) : int'(ifW.ovf[a]);
  endfunction

  task automatic checkVal(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic modelReset();
    for (int m = 0; m < 2; m++) begin
      for (int a = 0; a < AXES; a++) begin
        mPos[m][a] = 0;
        mVel[m][a] = 0;
        mOvf[m][a] = 1'b0;
      end
    end
    mBusy     = 1'b0;
    mDone     = 1'b0;
    passStart = -100;
  endtask

  // Axis a of a pass accepted at edge k is integrated at edge k+1+a.
  task automatic modelEdge();
    int cur;
    int sum;
    int res;
    bit ov;
    bit upd;
    logic signed [7:0]  v8;
    logic signed [15:0] p16;
    cur = edgeCnt - passStart - 1;
    upd = (cur >= 0) && (cur < AXES);
    for (int m = 0; m < 2; m++) begin
      if (tClr) begin
        for (int a = 0; a < AXES; a++) mOvf[m][a] = 1'b0;
      end
      if (upd) begin
        sum = mPos[m][cur] + mVel[m][cur];
        ov  = (sum > PMAX) || (sum < PMIN);
        res = sum;
        if (m == 0) begin
          if (sum > PMAX) res = PMAX;
          if (sum < PMIN) res = PMIN;
        end else begin
          if (sum > PMAX) res = sum - 65536;
          if (sum < PMIN) res = sum + 65536;
        end
        if (!(tWrEn && tWrPos && int'(tAxis) == cur)) begin
          mPos[m][cur] = res;
          if (ov) mOvf[m][cur] = 1'b1;
        end
      end
      if (tWrEn && int'(tAxis) < AXES) begin
        if (tWrPos) begin
          p16 = tData;
          mPos[m][tAxis] = int'(p16);
        end else begin
          v8 = tData[7:0];
          mVel[m][tAxis] = int'(v8);
        end
      end
    end
    mDone = (cur == AXES - 1);
    if (!upd && tStep) passStart = edgeCnt;
    mBusy = ((edgeCnt - passStart) >= 0) && ((edgeCnt - passStart) < AXES);
    edgeCnt++;
  endtask

  task automatic checkOutput(input string tag);
    for (int m = 0; m < 2; m++) begin
      for (int a = 0; a < AXES; a++) begin
        checkVal($sformatf("%s.%s.pos%0d", tag, m ? "wrap" : "sat", a), dutPos(m, a), mPos[m][a]);
        checkVal($sformatf("%s.%s.ovf%0d", tag, m ? "wrap" : "sat", a), dutOvf(m, a), int'(mOvf[m][a]));
      end
    end
    checkVal({tag, ".sat.busy"},  int'(ifS.busy), int'(mBusy));
    checkVal({tag, ".sat.done"},  int'(ifS.done), int'(mDone));
    checkVal({tag, ".wrap.busy"}, int'(ifW.busy), int'(mBusy));
    checkVal({tag, ".wrap.done"}, int'(ifW.done), int'(mDone));
  endtask

  task automatic applyStimulus(input logic s, input logic we, input logic wp,
                               input logic [1:0] ax, input logic [15:0] d,
                               input logic c, input string tag);
    tStep  = s;
    tWrEn  = we;
    tWrPos = wp;
    tAxis  = ax;
    tData  = d;
    tClr   = c;
    @(posedge clk);
    modelEdge();
    #1;
    if (ifS.done) doneSeen++;
    checkOutput(tag);
  endtask

  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, 2'd0, 16'd0, 1'b0, tag);
  endtask

  initial begin
    // One reset-then-pass scenario as hand-derived per-cycle vectors.
    vecs[0] = '{1'b0, 1'b1, 1'b0, 2'd0, 16'd5,     1'b0, 0, 0,  0, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 1'b1, 1'b0, 2'd1, 16'hFFFD,  1'b0, 0, 0,  0, 1'b0, 1'b0};
    vecs[2] = '{1'b0, 1'b1, 1'b0, 2'd2, 16'd1,     1'b0, 0, 0,  0, 1'b0, 1'b0};
    vecs[3] = '{1'b1, 1'b0, 1'b0, 2'd0, 16'd0,     1'b0, 0, 0,  0, 1'b1, 1'b0};
    vecs[4] = '{1'b0, 1'b0, 1'b0, 2'd0, 16'd0,     1'b0, 5, 0,  0, 1'b1, 1'b0};
    vecs[5] = '{1'b0, 1'b0, 1'b0, 2'd0, 16'd0,     1'b0, 5, -3, 0, 1'b1, 1'b0};
    vecs[6] = '{1'b0, 1'b0, 1'b0, 2'd0, 16'd0,     1'b0, 5, -3, 1, 1'b0, 1'b1};
    vecs[7] = '{1'b0, 1'b0, 1'b0, 2'd0, 16'd0,     1'b0, 5, -3, 1, 1'b0, 1'b0};

    modelReset();
    #7;
    checkOutput("reset");
    #5 rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i].step, vecs[i].wrEn, vecs[i].wrPos, vecs[i].axis,
                    vecs[i].data, vecs[i].clr, $sformatf("vec%0d", i));
      checkVal($sformatf("vec%0d.pos0", i), dutPos(0, 0), vecs[i].expPos0);
      checkVal($sformatf("vec%0d.pos1", i), dutPos(0, 1), vecs[i].expPos1);
      checkVal($sformatf("vec%0d.pos2", i), dutPos(0, 2), vecs[i].expPos2);
      checkVal($sformatf("vec%0d.busy", i), int'(ifS.busy), int'(vecs[i].expBusy));
      checkVal($sformatf("vec%0d.done", i), int'(ifS.done), int'(vecs[i].expDone));
    end

    // Overflow pass: axis 0 overflows upward and axis 1 overflows downward.
    applyStimulus(1'b0, 1'b1, 1'b1, 2'd0, 16'd32760, 1'b0, "ovfSetup");
    applyStimulus(1'b0, 1'b1, 1'b0, 2'd0, 16'd10,    1'b0, "ovfSetup");
    applyStimulus(1'b0, 1'b1, 1'b1, 2'd1, 16'h8003,  1'b0, "ovfSetup");
    applyStimulus(1'b0, 1'b1, 1'b0, 2'd1, 16'hFFF8,  1'b0, "ovfSetup");
    applyStimulus(1'b1, 1'b0, 1'b0, 2'd0, 16'd0,     1'b0, "ovfStep");
    idle(3, "ovfPass");
    checkVal("satPos0", dutPos(0, 0), 32767);
    checkVal("satOvf0", dutOvf(0, 0), 1);
    checkVal("satPos1", dutPos(0, 1), -32768);
    checkVal("satOvf1", dutOvf(0, 1), 1);
    checkVal("wrapPos0", dutPos(1, 0), -32766);
    checkVal("wrapOvf0", dutOvf(1, 0), 1);
    checkVal("wrapPos1", dutPos(1, 1), 32763);
    checkVal("wrapPos2", dutPos(1, 2), 2);
    applyStimulus(1'b0, 1'b0, 1'b0, 2'd0, 16'd0, 1'b1, "clrOvf");
    checkVal("clrSatOvf",  int'(ifS.ovf), 0);
    checkVal("clrWrapOvf", int'(ifW.ovf), 0);

    // Collisions: position write on axis 1's update edge, velocity write on axis 2's.
    applyStimulus(1'b1, 1'b0, 1'b0, 2'd0, 16'd0,   1'b0, "colStep");
    applyStimulus(1'b0, 1'b0, 1'b0, 2'd0, 16'd0,   1'b0, "colAx0");
    applyStimulus(1'b0, 1'b1, 1'b1, 2'd1, 16'd100, 1'b0, "colPosWr");
    applyStimulus(1'b0, 1'b1, 1'b0, 2'd2, 16'd7,   1'b0, "colVelWr");
    checkVal("colSatPos1",  dutPos(0, 1), 100);
    checkVal("colSatOvf1",  dutOvf(0, 1), 0);
    checkVal("colWrapPos1", dutPos(1, 1), 100);
    checkVal("colSatPos2",  dutPos(0, 2), 3);
    applyStimulus(1'b1, 1'b0, 1'b0, 2'd0, 16'd0, 1'b0, "colStep2");
    idle(3, "colPass2");
    checkVal("newVelPos2", dutPos(0, 2), 10);
    checkVal("newVelPos1", dutPos(0, 1), 92);

    // Step held high: passes back to back, one done per pass.
    doneSeen = 0;
    for (int i = 0; i < 12; i++) applyStimulus(1'b1, 1'b0, 1'b0, 2'd0, 16'd0, 1'b0, "b2b");
    idle(4, "b2bTail");
    checkVal("b2bDones", doneSeen, 3);

    // A second step while busy is dropped.
    doneSeen = 0;
    applyStimulus(1'b1, 1'b0, 1'b0, 2'd0, 16'd0, 1'b0, "busyStep");
    applyStimulus(1'b1, 1'b0, 1'b0, 2'd0, 16'd0, 1'b0, "busyStep");
    idle(6, "busyTail");
    checkVal("busyStepDones", doneSeen, 1);

    // Writes aimed at a nonexistent axis change nothing.
    applyStimulus(1'b0, 1'b1, 1'b1, 2'd3, 16'h1234, 1'b0, "axis3Pos");
    applyStimulus(1'b0, 1'b1, 1'b0, 2'd3, 16'h0055, 1'b0, "axis3Vel");

    // Reset after axis 0 of a pass has been updated.
    applyStimulus(1'b1, 1'b0, 1'b0, 2'd0, 16'd0, 1'b0, "rstStep");
    applyStimulus(1'b0, 1'b0, 1'b0, 2'd0, 16'd0, 1'b0, "rstAx0");
    #2 rst = 1'b1;
    #1;
    modelReset();
    checkOutput("rstMid");
    checkVal("rstMidPos", int'(ifS.pos), 0);
    #1 rst = 1'b0;
    doneSeen = 0;
    idle(4, "rstAfter");
    checkVal("rstNoDone", doneSeen, 0);
    applyStimulus(1'b0, 1'b1, 1'b0, 2'd0, 16'd5,    1'b0, "rstVel");
    applyStimulus(1'b0, 1'b1, 1'b0, 2'd1, 16'hFFFD, 1'b0, "rstVel");
    applyStimulus(1'b0, 1'b1, 1'b0, 2'd2, 16'd1,    1'b0, "rstVel");
    applyStimulus(1'b1, 1'b0, 1'b0, 2'd0, 16'd0,    1'b0, "rstPass");
    idle(3, "rstPass");
    checkVal("rstPassPos0", dutPos(0, 0), 5);
    checkVal("rstPassPos1", dutPos(0, 1), -3);
    checkVal("rstPassPos2", dutPos(1, 2), 1);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      logic [15:0] d;
      d = 16'($urandom);
      if ($urandom_range(0, 3) == 0) d = {{8{d[7]}}, d[7:0]} + 16'h7F80;
      applyStimulus(1'($urandom_range(0, 2) == 0),
                    1'($urandom_range(0, 3) == 0),
                    1'($urandom_range(0, 1)),
                    2'($urandom_range(0, 3)),
                    d,
                    1'($urandom_range(0, 15) == 0),
                    "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
